// File: rtl/reg_writeback_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reg_writeback_queue
// Purpose  : Small in-order FIFO between the execute/writeback stage and the
//            write port of the 16x32 register bank. Results are drained one
//            per cycle into the bank. Pending, not-yet-written values are
//            forwarded to the two decode read addresses, so decode always
//            sees the newest value of a register whose write is still queued.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W    register data width
//   ADDR_W    register address width
//   DEPTH     queue entries (power of two, >= 2)
// Ports
//   clk                    clock, all state updates on rising edge
//   rst_n                  asynchronous active-low reset
//   in_valid/in_ready      result handshake from execute/writeback
//   in_dest/in_data        destination register and value of the result
//   rf_we                  bank write strobe (bank writes on edge with rf_we=1)
//   rf_dest/rf_din         bank write address/data (head entry)
//   rf_stall               bank write port busy, hold the head entry
//   srcadd1/srcadd2        decode read addresses
//   fwd1_hit/fwd2_hit      a queued entry targets srcadd1/srcadd2
//   fwd1_data/fwd2_data    newest queued value for srcadd1/srcadd2
//   count                  occupied entries
//   empty/full             count==0 / count==DEPTH
// ============================================================================
module reg_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_dest,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_dest,
  output logic [DATA_W-1:0]        rf_din,
  input  logic                     rf_stall,
  input  logic [ADDR_W-1:0]        srcadd1,
  input  logic [ADDR_W-1:0]        srcadd2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  // --------------------------------------------------------------------------
  // Storage and pointers
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;

  // Fields of the most recently drained entry. The slot itself may be
  // overwritten by a later push, so the bank-facing outputs keep their own
  // copy for the idle (empty) case.
  logic [ADDR_W-1:0]  r_last_dest;
  logic [DATA_W-1:0]  r_last_din;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

  // No pass-through: a full queue refuses input even when it pops this cycle.
  // Gating with rst_n drops in_ready immediately while reset is asserted.
  assign in_ready = !w_full && rst_n;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !w_empty && !rf_stall;

  assign empty = w_empty;
  assign full  = w_full;
  assign count = r_count;

  // --------------------------------------------------------------------------
  // Entry array. Because pointers are only equal when the queue is empty or
  // full, a push and a pop can never target the same slot in one cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i]  <= '0;
        r_data[i]  <= '0;
        r_valid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_tail == c_ptr_w'(i))) begin
          r_dest[i]  <= in_dest;
          r_data[i]  <= in_data;
          r_valid[i] <= 1'b1;
        end else if (w_pop && (r_head == c_ptr_w'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally at their full binary width.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_ptr_one;
      end
      if (w_pop) begin
        r_head <= r_head + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_dest <= '0;
      r_last_din  <= '0;
    end else if (w_pop) begin
      r_last_dest <= r_dest[r_head];
      r_last_din  <= r_data[r_head];
    end
  end

  // --------------------------------------------------------------------------
  // Bank write port: head entry while occupied, last drained entry otherwise.
  // --------------------------------------------------------------------------
  assign rf_we   = w_pop;
  assign rf_dest = w_empty ? r_last_dest : r_dest[r_head];
  assign rf_din  = w_empty ? r_last_din  : r_data[r_head];

  // --------------------------------------------------------------------------
  // Forwarding. Entries are scanned oldest (head) to newest, so a later match
  // overrides an earlier one and the newest queued value wins. The entry
  // being drained this cycle is still valid and still forwards; from the next
  // edge on the bank itself holds that value.
  // --------------------------------------------------------------------------
  logic [c_ptr_w-1:0] w_idx;

  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + c_ptr_w'(k);
      if (r_valid[w_idx] && (r_dest[w_idx] == srcadd1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = r_data[w_idx];
      end
      if (r_valid[w_idx] && (r_dest[w_idx] == srcadd2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = r_data[w_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_queue
// Purpose  : Directed bench for reg_writeback_queue. Accepted results are
//            pushed into a scoreboard queue; every cycle the head of that
//            queue predicts the bank write, and the queue contents predict
//            occupancy, flags and forwarding. A small bank model records what
//            the DUT actually wrote for end-of-test value checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0] rf_din;
  logic              rf_stall;
  logic [ADDR_W-1:0] srcadd1;
  logic [ADDR_W-1:0] srcadd2;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic [$clog2(DEPTH):0] count;
  logic              empty;
  logic              full;

  reg_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .rf_we     (rf_we),
    .rf_dest   (rf_dest),
    .rf_din    (rf_din),
    .rf_stall  (rf_stall),
    .srcadd1   (srcadd1),
    .srcadd2   (srcadd2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model fed by the DUT write port.
  logic [DATA_W-1:0] bank [16];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 16; b++) bank[b] <= '0;
    end else if (rf_we) begin
      bank[rf_dest] <= rf_din;
    end
  end

  // Scoreboard: {dest, data} of accepted results, oldest at the front.
  logic [ADDR_W+DATA_W-1:0] sb [$];
  logic [ADDR_W+DATA_W-1:0] m_last;

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check all outputs against the scoreboard at the falling
  // edge, then advance the model across the rising edge.
  task automatic cycle();
    logic acc;
    logic pop;
    logic [ADDR_W+DATA_W-1:0] inw;
    logic h1, h2;
    logic [DATA_W-1:0] d1, d2;
    @(negedge clk);
    pop = (sb.size() > 0) && !rf_stall;
    acc = in_valid && (sb.size() < DEPTH);
    inw = {in_dest, in_data};
    chk("in_ready", in_ready, sb.size() < DEPTH);
    chk("count", count, sb.size());
    chk("empty", empty, sb.size() == 0);
    chk("full", full, sb.size() == DEPTH);
    chk("rf_we", rf_we, pop);
    if (sb.size() > 0) begin
      chk("rf_dest", rf_dest, sb[0][ADDR_W+DATA_W-1:DATA_W]);
      chk("rf_din", rf_din, sb[0][DATA_W-1:0]);
    end else begin
      chk("rf_dest_hold", rf_dest, m_last[ADDR_W+DATA_W-1:DATA_W]);
      chk("rf_din_hold", rf_din, m_last[DATA_W-1:0]);
    end
    h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i][ADDR_W+DATA_W-1:DATA_W] == srcadd1) begin h1 = 1'b1; d1 = sb[i][DATA_W-1:0]; end
      if (sb[i][ADDR_W+DATA_W-1:DATA_W] == srcadd2) begin h2 = 1'b1; d2 = sb[i][DATA_W-1:0]; end
    end
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd1_data", fwd1_data, d1);
    chk("fwd2_hit", fwd2_hit, h2);
    chk("fwd2_data", fwd2_data, d2);
    @(posedge clk);
    if (pop) m_last = sb.pop_front();
    if (acc) sb.push_back(inw);
    #1;
  endtask

  int tbl [16] = '{10, 11, 12, 13, 34, 45, 36, 97, 38, 29, 110, 111, 112, 113, 114, 115};

  initial begin
    n_cmp = 0; n_err = 0;
    m_last = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_dest = '0; in_data = '0;
    rf_stall = 1'b0; srcadd1 = '0; srcadd2 = '0;

    // Reset state
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_dest", rf_dest, 0);
    chk("rst_rf_din", rf_din, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fwd1_hit", fwd1_hit, 0);
    chk("rst_fwd2_hit", fwd2_hit, 0);
    chk("rst_fwd1_data", fwd1_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // 1: sixteen back-to-back results, no stall
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_dest = ADDR_W'(i); in_data = DATA_W'(tbl[i]);
      srcadd1 = ADDR_W'(i); srcadd2 = ADDR_W'(i + 15);
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();
    chk("t1_empty", empty, 1);
    chk("t1_hold_dest", rf_dest, 15);
    chk("t1_hold_din", rf_din, 115);
    for (int i = 0; i < 16; i++) chk("t1_bank", bank[i], tbl[i]);

    // 2: fill under stall, fifth push refused, then drain
    rf_stall = 1'b1;
    in_valid = 1'b1; in_dest = 4'd3; in_data = 32'd13; cycle();
    in_dest = 4'd5; in_data = 32'd45; cycle();
    in_dest = 4'd7; in_data = 32'd97; cycle();
    in_dest = 4'd9; in_data = 32'd29; cycle();
    chk("t2_full", full, 1);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_count", count, 4);
    chk("t2_rf_we", rf_we, 0);
    in_dest = 4'd11; in_data = 32'h55; cycle();
    in_valid = 1'b0; rf_stall = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("t2_b3", bank[3], 13);
    chk("t2_b5", bank[5], 45);
    chk("t2_b7", bank[7], 97);
    chk("t2_b9", bank[9], 29);
    chk("t2_b11", bank[11], 111);

    // 3: forwarding picks the newest of two writes to r6
    rf_stall = 1'b1; srcadd1 = 4'd6; srcadd2 = 4'd15;
    in_valid = 1'b1; in_dest = 4'd6; in_data = 32'd36; cycle();
    in_data = 32'd200; cycle();
    in_valid = 1'b0;
    chk("t3_fwd1_hit", fwd1_hit, 1);
    chk("t3_fwd1_data", fwd1_data, 200);
    chk("t3_fwd2_hit", fwd2_hit, 0);
    rf_stall = 1'b0;
    cycle(); cycle(); cycle();
    chk("t3_fwd1_gone", fwd1_hit, 0);
    chk("t3_bank6", bank[6], 200);

    // 4: full queue with continuous input, pointers wrap repeatedly
    rf_stall = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_dest = ADDR_W'(i); in_data = $urandom; cycle();
    end
    rf_stall = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_dest = ADDR_W'($urandom_range(0, 15)); in_data = $urandom;
      srcadd1 = ADDR_W'($urandom_range(0, 3)); srcadd2 = in_dest;
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("t4_empty", empty, 1);

    // 5: asynchronous reset with three queued entries
    rf_stall = 1'b1; srcadd1 = 4'd1; srcadd2 = 4'd2; in_valid = 1'b1;
    in_dest = 4'd1; in_data = 32'hA1; cycle();
    in_dest = 4'd2; in_data = 32'hA2; cycle();
    in_dest = 4'd4; in_data = 32'hA4; cycle();
    in_valid = 1'b0;
    chk("t5_pre_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_rf_we", rf_we, 0);
    chk("t5_fwd1_hit", fwd1_hit, 0);
    chk("t5_fwd2_hit", fwd2_hit, 0);
    chk("t5_in_ready", in_ready, 0);
    sb.delete();
    m_last = '0;
    rf_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("t5_b1", bank[1], 0);
    chk("t5_b2", bank[2], 0);
    chk("t5_b4", bank[4], 0);

    // 6: occupancy 2 with simultaneous push and pop for 10 cycles
    rf_stall = 1'b1; in_valid = 1'b1;
    in_dest = 4'd8; in_data = 32'h800; cycle();
    in_dest = 4'd9; in_data = 32'h900; cycle();
    rf_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_dest = ADDR_W'(i + 10); in_data = 32'h1000 + DATA_W'(i);
      srcadd1 = ADDR_W'(i + 9); srcadd2 = ADDR_W'(i + 8);
      cycle();
      chk("t6_count", count, 2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_empty", empty, 1);
    chk("t6_bank3", bank[3], 32'h1009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Buffers execute-stage results (destination register, 32-bit value) in a small FIFO and drains them, one per cycle, into the write port of the 16×32 register bank. It also forwards pending, not-yet-written values to the two register-bank read addresses, so decode sees the newest value of a register whose write is still queued. It sits between the execute/writeback stage and the register bank's dest/Din write port.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 4, register address width (16 registers)
- DEPTH, 4, queue entries; power of two, ≥2

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  result present on in_dest/in_data
- in_ready  out  1  queue can accept a result this cycle
- in_dest  in  ADDR_W  destination register of incoming result
- in_data  in  DATA_W  incoming result value
- rf_we  out  1  write strobe to register bank; bank writes on the clk edge where rf_we=1
- rf_dest  out  ADDR_W  register bank write address (head entry)
- rf_din  out  DATA_W  register bank write data (head entry)
- rf_stall  in  1  bank write port unavailable this cycle; hold head entry
- srcadd1, srcadd2  in  ADDR_W  register bank read addresses from decode
- fwd1_hit, fwd2_hit  out  1  a queued entry targets srcadd1 / srcadd2
- fwd1_data, fwd2_data  out  DATA_W  newest queued value for srcadd1 / srcadd2
- count  out  $clog2(DEPTH)+1  occupied entries
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- Storage: DEPTH entries {dest, data, valid}; head pointer, tail pointer, count register; pointers wrap modulo DEPTH.
- Push: in_valid && in_ready at a clk edge writes {in_dest, in_data} at tail, sets valid, tail+1.
- in_ready = !full && rst_n. No pass-through: a full queue does not accept even when popping in the same cycle.
- Drain: rf_we = !empty && !rf_stall; rf_dest/rf_din = head entry (combinational from storage). At a clk edge with rf_we=1 head entry valid cleared, head+1.
- When empty: rf_we=0, rf_dest/rf_din hold the last-popped entry's fields (don't-care to the bank, but must not be X after first use; 0 after reset).
- Simultaneous push and pop: both occur, count unchanged; push into a full queue never happens (in_ready=0).
- Forwarding (combinational): for each read port, compare srcaddN with dest of every valid entry; hitN=1 if any match; dataN = matching entry nearest the tail (newest). Entry being popped this cycle still counts as valid and forwards; after the pop edge the bank holds the value.
- Multiple writes to the same register are kept and drained in order; no merging.
- Register 0 is an ordinary register: writes and forwarding apply to it.
- Data and addresses are passed unmodified; no width conversion.

## Timing
- Reset (rst_n low, asynchronous): count=0, head=tail=0, all valid=0, empty=1, full=0, rf_we=0, rf_dest=0, rf_din=0, in_ready=0, fwd hits 0, fwd data 0. in_ready rises combinationally on rst_n deassertion.
- Reset mid-operation discards all queued entries; no bank writes of discarded entries.
- Latency: result pushed at edge k appears on rf_we/rf_dest/rf_din in cycle k+1 (if it is at head and rf_stall=0) and is written to the bank at edge k+1.
- Forwarding: entry pushed at edge k is visible on fwdN outputs from cycle k+1 until the edge that pops it.
- Throughput: 1 push and 1 pop per cycle sustained.
- rf_stall holds head and outputs stable; queue continues to accept until full.

## Test plan
- Reset then push 16 results dest=0..15, data=10,11,12,13,34,45,36,97,38,29,110..115, rf_stall=0 -> rf_we high one cycle per entry in order, rf_dest=0..15, rf_din matches; count never exceeds 1; empty=1 at end.
- rf_stall=1, push dest=3/13, dest=5/45, dest=7/97, dest=9/29 -> full=1, in_ready=0, count=4, rf_we=0; fifth push not accepted; release stall -> four writes in order over four cycles.
- Stall, push dest=6/36 then dest=6/200; srcadd1=6, srcadd2=15 -> fwd1_hit=1 fwd1_data=200, fwd2_hit=0; after drain fwd1_hit=0 and bank r6=200.
- Full queue, rf_stall=0, in_valid=1 every cycle -> one pop per cycle, push accepted only on cycles after a pop frees an entry; no entry lost or duplicated; pointers wrap past DEPTH-1 correctly.
- Queue holding 3 entries, assert rst_n=0 mid-cycle -> immediately count=0, empty=1, rf_we=0, fwd hits 0; after release no bank writes of old entries.
- Count 2, simultaneous push and pop for 10 cycles -> count stays 2, write order matches push order.
